// File: rtl/fp_classify_pipe.sv
// Two-stage IEEE-754 operand classifier (single/double) with valid/ready flow control,
// NaN-boxing check for singles held in a 64-bit register, and a sticky sNaN flag.
module fp_classify_pipe #(
    parameter int FLEN      = 64,
    parameter int SUPPORT_D = 1,
    parameter int TAG_W     = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [FLEN-1:0]  i_fp_in,
    input  logic             i_fmt,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [9:0]       o_class,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_snan_seen,
    input  logic             i_clr_sticky
);

    localparam bit EFF_D   = (FLEN == 64) && (SUPPORT_D != 0);
    localparam bit BOX_CHK = (FLEN == 64);

    logic [63:0]      w_fp64;
    logic             w_is_d;
    logic             w_sign;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_zero;
    logic             w_man_msb;
    logic             w_box_ok;
    logic             w_in_xfer;
    logic             w_s2_load;
    logic             w_out_xfer;
    logic [9:0]       w_class;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_exp_ones;
    logic             r_s1_exp_zero;
    logic             r_s1_man_zero;
    logic             r_s1_man_msb;
    logic             r_s1_box_ok;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [9:0]       r_class;
    logic [TAG_W-1:0] r_tag;
    logic             r_snan_seen;

    generate
        if (FLEN == 64) begin : g_f64
            assign w_fp64 = i_fp_in;
        end else begin : g_f32
            assign w_fp64 = {32'h0, i_fp_in};
        end
    endgenerate

    always_comb begin
        w_is_d = EFF_D && i_fmt;
        if (w_is_d) begin
            w_sign     = w_fp64[63];
            w_exp_ones = &w_fp64[62:52];
            w_exp_zero = ~|w_fp64[62:52];
            w_man_zero = ~|w_fp64[51:0];
            w_man_msb  = w_fp64[51];
        end else begin
            w_sign     = w_fp64[31];
            w_exp_ones = &w_fp64[30:23];
            w_exp_zero = ~|w_fp64[30:23];
            w_man_zero = ~|w_fp64[22:0];
            w_man_msb  = w_fp64[22];
        end
        // A single in a 64-bit register is only valid when NaN-boxed (upper half all ones).
        w_box_ok = w_is_d || !BOX_CHK || (&w_fp64[63:32]);
    end

    assign w_s2_load  = r_s1_valid && (!r_s2_valid || i_ready);
    assign o_ready    = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = r_s2_valid && i_ready;

    always_comb begin
        w_class = '0;
        if (!r_s1_box_ok) begin
            w_class[9] = 1'b1;
        end else if (r_s1_exp_ones) begin
            if (r_s1_man_zero)     w_class[r_s1_sign ? 0 : 7] = 1'b1;
            else if (r_s1_man_msb) w_class[9] = 1'b1;
            else                   w_class[8] = 1'b1;
        end else if (r_s1_exp_zero) begin
            if (r_s1_man_zero) w_class[r_s1_sign ? 3 : 4] = 1'b1;
            else               w_class[r_s1_sign ? 2 : 5] = 1'b1;
        end else begin
            w_class[r_s1_sign ? 1 : 6] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_exp_ones <= 1'b0;
            r_s1_exp_zero <= 1'b0;
            r_s1_man_zero <= 1'b0;
            r_s1_man_msb  <= 1'b0;
            r_s1_box_ok   <= 1'b0;
            r_s1_tag      <= '0;
        end else begin
            if (i_flush)      r_s1_valid <= 1'b0;
            else if (o_ready) r_s1_valid <= i_valid;
            if (w_in_xfer) begin
                r_s1_sign     <= w_sign;
                r_s1_exp_ones <= w_exp_ones;
                r_s1_exp_zero <= w_exp_zero;
                r_s1_man_zero <= w_man_zero;
                r_s1_man_msb  <= w_man_msb;
                r_s1_box_ok   <= w_box_ok;
                r_s1_tag      <= i_tag;
            end
        end
    end

    // r_class is zeroed whenever the stage empties so o_class is 0 while o_valid is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_class    <= '0;
            r_tag      <= '0;
        end else if (i_flush) begin
            r_s2_valid <= 1'b0;
            r_class    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_class    <= w_class;
            r_tag      <= r_s1_tag;
        end else if (i_ready) begin
            r_s2_valid <= 1'b0;
            r_class    <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                     r_snan_seen <= 1'b0;
        else if (w_out_xfer && r_class[8]) r_snan_seen <= 1'b1;
        else if (i_clr_sticky)            r_snan_seen <= 1'b0;
    end

    assign o_valid     = r_s2_valid;
    assign o_class     = r_class;
    assign o_tag       = r_tag;
    assign o_snan_seen = r_snan_seen;

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Scoreboard bench for fp_classify_pipe: directed vectors push expected class/tag,
// a negedge monitor pops and compares on every output transfer.
module tb_fp_classify_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_fp_in;
    logic        i_fmt;
    logic [4:0]  i_tag;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [9:0]  o_class;
    logic [4:0]  o_tag;
    logic        o_snan_seen;
    logic        i_clr_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    logic [14:0] exp_q[$];

    typedef struct {
        logic [63:0] fp;
        logic        fmt;
        logic [9:0]  cls;
    } vec_t;

    vec_t vecs[12];
    vec_t strm[5];

    fp_classify_pipe #(.FLEN(64), .SUPPORT_D(1), .TAG_W(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_fp_in(i_fp_in), .i_fmt(i_fmt), .i_tag(i_tag), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_class(o_class), .o_tag(o_tag),
        .o_snan_seen(o_snan_seen), .i_clr_sticky(i_clr_sticky)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an output transfer happens at the next rising edge when o_valid && i_ready.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got class %h tag %h expected none", o_class, o_tag);
                end else begin
                    logic [14:0] e;
                    e = exp_q.pop_front();
                    check("class", {54'h0, o_class}, {54'h0, e[14:5]});
                    check("tag", {59'h0, o_tag}, {59'h0, e[4:0]});
                end
            end else if (!o_valid) begin
                check("class_idle_zero", {54'h0, o_class}, 64'h0);
            end
        end
    end

    task automatic send(input logic [63:0] fp, input logic fmt, input logic [4:0] tag, input logic [9:0] cls);
        bit accepted;
        accepted = 1'b0;
        i_valid = 1'b1; i_fp_in = fp; i_fmt = fmt; i_tag = tag;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                accepted = 1'b1;
                exp_q.push_back({cls, tag});
            end
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (!accepted) check("send_accept", 64'h0, 64'h1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge i_clk);
        check("drain_timeout", 64'(exp_q.size()), 64'h0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{64'h00000000_3F800000, 1'b0, 10'h200};  // unboxed single
        vecs[1]  = '{64'h7FF8000000000000, 1'b1, 10'h200};
        vecs[2]  = '{64'h8000000000000001, 1'b1, 10'h004};
        vecs[3]  = '{64'h3FF0000000000000, 1'b1, 10'h040};
        vecs[4]  = '{64'hFFFFFFFF_7FC00000, 1'b0, 10'h200};
        vecs[5]  = '{64'hFFFFFFFF_FF800001, 1'b0, 10'h100};
        vecs[6]  = '{64'hFFF0000000000000, 1'b1, 10'h001};
        vecs[7]  = '{64'h0000000000000000, 1'b1, 10'h010};
        vecs[8]  = '{64'h8000000000000000, 1'b1, 10'h008};
        vecs[9]  = '{64'h000FFFFFFFFFFFFF, 1'b1, 10'h020};
        vecs[10] = '{64'hC000000000000000, 1'b1, 10'h002};
        vecs[11] = '{64'hFFFFFFFF_7F7FFFFF, 1'b0, 10'h040};
        strm[0]  = '{64'hFFFFFFFF_00000000, 1'b0, 10'h010};
        strm[1]  = '{64'hFFFFFFFF_80000000, 1'b0, 10'h008};
        strm[2]  = '{64'hFFFFFFFF_00000001, 1'b0, 10'h020};
        strm[3]  = '{64'hFFFFFFFF_BF800000, 1'b0, 10'h002};
        strm[4]  = '{64'hFFFFFFFF_FF800000, 1'b0, 10'h001};

        i_rst_n = 1'b0; i_valid = 1'b0; i_fp_in = '0; i_fmt = 1'b0; i_tag = '0;
        i_flush = 1'b0; i_ready = 1'b1; i_clr_sticky = 1'b0;
        #2;
        check("rst_o_valid", {63'h0, o_valid}, 64'h0);
        check("rst_o_class", {54'h0, o_class}, 64'h0);
        check("rst_o_tag", {59'h0, o_tag}, 64'h0);
        check("rst_snan", {63'h0, o_snan_seen}, 64'h0);
        check("rst_o_ready", {63'h0, o_ready}, 64'h1);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Boxed +inf single with latency check
        send(64'hFFFFFFFF_7F800000, 1'b0, 5'h11, 10'h080);
        check("latency_s1", {63'h0, o_valid}, 64'h0);
        @(posedge i_clk);
        #1;
        check("latency_s2", {63'h0, o_valid}, 64'h1);
        wait_idle();

        // Double sNaN accepted while clear is held: set wins
        send(64'h7FF0000000000001, 1'b1, 5'h03, 10'h100);
        i_clr_sticky = 1'b1;
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_clr_sticky = 1'b0;
        check("snan_set_wins", {63'h0, o_snan_seen}, 64'h1);
        wait_idle();
        i_clr_sticky = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_sticky = 1'b0;
        check("snan_cleared", {63'h0, o_snan_seen}, 64'h0);
        send(64'hFFFFFFFF_7F800001, 1'b0, 5'h04, 10'h100);
        wait_idle();
        check("snan_set_single", {63'h0, o_snan_seen}, 64'h1);
        i_clr_sticky = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_sticky = 1'b0;
        check("snan_cleared2", {63'h0, o_snan_seen}, 64'h0);

        foreach (vecs[i]) send(vecs[i].fp, vecs[i].fmt, 5'(i + 8), vecs[i].cls);
        wait_idle();

        // Stream with downstream stall for three cycles
        fork
            begin
                foreach (strm[i]) send(strm[i].fp, strm[i].fmt, 5'(i + 1), strm[i].cls);
            end
            begin
                repeat (2) @(posedge i_clk);
                #1 i_ready = 1'b0;
                @(negedge i_clk);
                check("stall_o_ready_low", {63'h0, o_ready}, 64'h0);
                check("stall_o_valid_held", {63'h0, o_valid}, 64'h1);
                repeat (3) @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        wait_idle();

        // Flush with two operands in flight and a third offered
        i_ready = 1'b0;
        i_valid = 1'b1; i_fp_in = 64'h3FF0000000000000; i_fmt = 1'b1; i_tag = 5'h1A;
        @(posedge i_clk);
        #1 i_fp_in = 64'hBFF0000000000000; i_tag = 5'h1B;
        @(posedge i_clk);
        #1;
        check("preflush_o_valid", {63'h0, o_valid}, 64'h1);
        i_flush = 1'b1; i_fp_in = 64'h0; i_tag = 5'h1C;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush_o_valid", {63'h0, o_valid}, 64'h0);
        check("flush_o_ready", {63'h0, o_ready}, 64'h1);
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        check("flush_no_result", {63'h0, o_valid}, 64'h0);

        // Asynchronous reset while a stalled result is held
        i_ready = 1'b0;
        send(64'h3FF0000000000000, 1'b1, 5'h0E, 10'h040);
        for (int k = 0; k < 10 && !o_valid; k++) begin
            @(posedge i_clk);
            #1;
        end
        check("held_o_valid", {63'h0, o_valid}, 64'h1);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_o_valid", {63'h0, o_valid}, 64'h0);
        check("async_rst_o_class", {54'h0, o_class}, 64'h0);
        check("async_rst_o_ready", {63'h0, o_ready}, 64'h1);
        exp_q.delete();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        check("post_rst_no_result", {63'h0, o_valid}, 64'h0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_classify_pipe.md
FP_CLASSIFY_PIPE -- requirements
Module: fp_classify_pipe

Interface
REQ-001 Parameter FLEN, default 64, register width of FP operand; legal values 32 and 64 only.
REQ-002 Parameter SUPPORT_D, default 1, enables double-precision classification; treated as 0 when FLEN=32.
REQ-003 Parameter TAG_W, default 5, width of the opaque tag carried alongside each operand.
REQ-004 i_clk  input  1  sole clock, rising-edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  upstream operand valid.
REQ-007 o_ready  output  1  block can accept an operand this cycle.
REQ-008 i_fp_in  input  FLEN  operand bits.
REQ-009 i_fmt  input  1  0 = single (bits 31:0), 1 = double (bits 63:0).
REQ-010 i_tag  input  TAG_W  tag, returned unchanged with the result.
REQ-011 i_flush  input  1  synchronous pipeline kill.
REQ-012 o_valid  output  1  result valid.
REQ-013 i_ready  input  1  downstream accepts result.
REQ-014 o_class  output  10  one-hot class: [0] -inf, [1] -normal, [2] -subnormal, [3] -0, [4] +0, [5] +subnormal, [6] +normal, [7] +inf, [8] sNaN, [9] qNaN.
REQ-015 o_tag  output  TAG_W  tag of the presented result.
REQ-016 o_snan_seen  output  1  sticky flag, set when any sNaN result is accepted downstream.
REQ-017 i_clr_sticky  input  1  synchronous clear of o_snan_seen.

Function
REQ-018 The block SHALL be a two-stage pipeline: S1 registers decoded fields (sign, exp-all-ones, exp-zero, mantissa-zero, mantissa MSB, box-ok, tag); S2 registers the one-hot o_class and o_tag.
REQ-019 A transfer SHALL occur on a rising edge with i_valid && o_ready (input) or o_valid && i_ready (output).
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to o_valid with no stall; throughput 1 per cycle.
REQ-021 S2 SHALL load when S1 is valid and (S2 empty or i_ready); S2 SHALL hold contents and o_valid while o_valid && !i_ready.
REQ-022 o_ready SHALL equal !s1_valid || s2_load (combinational), so no operand is dropped or duplicated under backpressure.
REQ-023 Single format: sign bit 31, exp 30:23, mantissa 22:0; double format: sign 63, exp 62:52, mantissa 51:0.
REQ-024 Decode: exp all ones & mantissa zero -> inf by sign; exp all ones & mantissa nonzero -> qNaN if mantissa MSB=1 else sNaN (sign ignored); exp zero & mantissa zero -> zero by sign; exp zero & mantissa nonzero -> subnormal by sign; otherwise normal by sign.
REQ-025 With FLEN=64 and i_fmt=0, if bits 63:32 are not all ones the operand SHALL classify as qNaN (o_class=10'h200) regardless of bits 31:0.
REQ-026 When effective SUPPORT_D=0, i_fmt SHALL be ignored and single format used.
REQ-027 o_class SHALL be exactly one-hot whenever o_valid=1 and 10'h000 whenever o_valid=0.
REQ-028 i_flush=1 SHALL clear both stage valid bits at the edge; an input offered in the same cycle SHALL be discarded; o_ready SHALL be 1 the following cycle.
REQ-029 o_snan_seen SHALL set on an output transfer with o_class[8]=1; i_clr_sticky SHALL clear it; if both occur in one cycle, set SHALL win.

Reset
REQ-030 While i_rst_n=0 (asynchronously on assertion): s1_valid=0, o_valid=0, o_class=0, o_tag=0, o_snan_seen=0; o_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operands; no result SHALL appear after deassertion unless new input is accepted.

Verification
REQ-032 FLEN=64, fmt=0, i_fp_in=64'hFFFFFFFF_7F800000, i_ready=1 -> 2 cycles later o_valid=1, o_class=10'h080, tag echoed.
REQ-033 fmt=1, i_fp_in=64'h7FF0000000000001 -> o_class=10'h100, o_snan_seen=1 after accept; then i_clr_sticky -> 0.
REQ-034 fmt=0, i_fp_in=64'h00000000_3F800000 (unboxed) -> o_class=10'h200.
REQ-035 Stream 5 operands {+0, -0, +sub 0x00000001, -norm 0xBF800000, -inf 0xFF800000} with i_ready low for cycles 3-5 -> outputs 10'h010,10'h008,10'h020,10'h002,10'h001 in order, each exactly once, o_ready=0 while both stages full.
REQ-036 Two operands in flight, assert i_flush one cycle -> o_valid=0 next cycle, no results emitted.
REQ-037 Assert i_rst_n=0 with a stalled result held -> o_valid and o_class drop to 0 immediately without a clock edge.
